muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  launch operation; sampled only in IDLE.
REQ-004 SHALL have port: op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port: a  input  32  multiplicand/dividend (rs).
REQ-006 SHALL have port: b  input  32  multiplier/divisor (rt).
REQ-007 SHALL have port: mthi  input  1  load HI from wdata.
REQ-008 SHALL have port: mtlo  input  1  load LO from wdata.
REQ-009 SHALL have port: wdata  input  32  MTHI/MTLO data.
REQ-010 SHALL have port: hi  output  32  HI register.
REQ-011 SHALL have port: lo  output  32  LO register.
REQ-012 SHALL have port: busy  output  1  high in any state other than IDLE; pipeline stalls MFHI/MFLO/MULT/DIV/MTHI/MTLO on it.
REQ-013 SHALL have port: done  output  1  one-cycle pulse when HI/LO hold a new result.

Function
REQ-014 SHALL implement states IDLE, RUN, FIX; busy = (state != IDLE), combinational from state.
REQ-015 IDLE with start=1 SHALL latch a, b, op, magnitudes of a and b (signed ops), result sign flags, clear 5-bit iteration counter, go to RUN.
REQ-016 RUN SHALL perform one radix-2 step per cycle (shift-add multiply or restoring divide on magnitudes) for exactly 32 cycles, then go to FIX.
REQ-017 FIX SHALL apply sign correction and write HI/LO on its exiting edge, then return to IDLE; done SHALL be high for the first IDLE cycle after FIX.
REQ-018 Latency SHALL be 34 edges from the start-sampling edge to the HI/LO write; done visible the cycle after.
REQ-019 MULT/MULTU SHALL produce the full 64-bit product {HI,LO} (two's complement for MULT).
REQ-020 DIV/DIVU SHALL produce LO = quotient, HI = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-021 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 Divisor zero (DIV/DIVU) SHALL skip RUN: IDLE->FIX, HI/LO unchanged, done still pulsed after FIX.
REQ-023 start while busy SHALL be ignored; operands, state and counter unaffected.
REQ-024 mthi/mtlo in IDLE SHALL write HI/LO on the next edge; both may assert together.
REQ-025 mthi/mtlo while busy SHALL be ignored.
REQ-026 start together with mthi/mtlo in IDLE: start wins, writes ignored.
REQ-027 HI/LO SHALL otherwise hold value indefinitely; done SHALL not assert for mthi/mtlo.

Reset
REQ-028 rst SHALL asynchronously force state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0.
REQ-029 rst mid-operation SHALL abandon the operation with no HI/LO write and no done pulse.
REQ-030 First start after rst deasserts SHALL behave per REQ-015.

Configuration
REQ-031 Macro MULDIV_FAST_MUL_EN defined: MULT/MULTU SHALL go IDLE->FIX computing the product with a single-cycle multiplier; HI/LO written 2 edges after start edge.
REQ-032 MULDIV_FAST_MUL_EN undefined: MULT/MULTU SHALL use the 32-cycle RUN path of REQ-016; division SHALL be iterative in both builds.

Verification
REQ-033 MULTU a=0xFFFFFFFF b=2 -> HI=0x00000001, LO=0xFFFFFFFE, done exactly 35 cycles after start cycle (3 with MULDIV_FAST_MUL_EN).
REQ-034 MULT a=0xFFFFFFFD(-3) b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV a=-7 b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 DIVU a=0x1234 b=0 after mthi/mtlo loading 0xAAAA/0x5555 -> HI=0xAAAA, LO=0x5555 unchanged, done pulses after FIX.
REQ-036 Second start and mthi during busy -> ignored; first result (DIVU 100/7 -> LO=14, HI=2) intact.
REQ-037 rst asserted at RUN cycle 10 of DIVU -> hi=lo=0, busy=0 immediately, no done; subsequent DIVU 9/3 -> LO=3, HI=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32-step shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state;
  state_t      state_next;
  logic        fix_phase;
  logic [4:0]  count;
  logic [63:0] acc;
  logic [31:0] opnd;
  logic        is_div;
  logic        neg_lo;
  logic        neg_hi;
  logic        div_zero;

  logic        is_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        zero_div;
  logic        fast_mul;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] step_next;
  logic [63:0] fixed;

  assign is_signed = ~op[0];
  assign mag_a     = (is_signed && a[31]) ? (32'd0 - a) : a;
  assign mag_b     = (is_signed && b[31]) ? (32'd0 - b) : b;
  assign zero_div  = op[1] && (b == 32'd0);
`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul  = ~op[1];
`else
  assign fast_mul  = 1'b0;
`endif

  // acc holds {product high, multiplier/product low} or {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign div_shift = {acc[63:32], acc[31]};
  assign div_diff  = div_shift - {1'b0, opnd};

  always_comb begin
    step_next = acc;
    if (is_div) begin
      if (div_diff[32])
        step_next = {div_shift[31:0], acc[30:0], 1'b0};
      else
        step_next = {div_diff[31:0], acc[30:0], 1'b1};
    end else begin
      step_next = {mul_sum, acc[31:1]};
    end
  end

  always_comb begin
    fixed = acc;
    if (is_div) begin
      fixed[63:32] = neg_hi ? (32'd0 - acc[63:32]) : acc[63:32];
      fixed[31:0]  = neg_lo ? (32'd0 - acc[31:0])  : acc[31:0];
    end else if (neg_lo) begin
      fixed = 64'd0 - acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start)
          state_next = (zero_div || fast_mul) ? FIX : RUN;
      end
      RUN: begin
        if (count == 5'd31)
          state_next = FIX;
      end
      FIX: begin
        if (fix_phase)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fix_phase <= 1'b0;
      count     <= 5'd0;
      acc       <= 64'd0;
      opnd      <= 32'd0;
      is_div    <= 1'b0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          fix_phase <= 1'b0;
          count     <= 5'd0;
          if (start) begin
            is_div   <= op[1];
            div_zero <= zero_div;
            neg_lo   <= is_signed && (a[31] ^ b[31]);
            neg_hi   <= is_signed && op[1] && a[31];
            if (op[1]) begin
              acc  <= {32'd0, mag_a};
              opnd <= mag_b;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              acc  <= {32'd0, mag_a} * {32'd0, mag_b};
`else
              acc  <= {32'd0, mag_b};
`endif
              opnd <= mag_a;
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          acc   <= step_next;
          count <= count + 5'd1;
        end
        FIX: begin
          // First FIX cycle applies the sign correction, second commits it.
          if (!fix_phase) begin
            fix_phase <= 1'b1;
            acc       <= fixed;
          end else begin
            fix_phase <= 1'b0;
            done      <= 1'b1;
            if (!div_zero) begin
              hi <= acc[63:32];
              lo <= acc[31:0];
            end
          end
        end
        default: fix_phase <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; expected values are hand-computed.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 35;
`endif
  localparam int DIV_LAT  = 35;
  localparam int ZERO_LAT = 3;

  muldiv_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives start for one cycle; returns at the falling edge of cycle 1 (first cycle after the start edge).
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = 32'd0; b = 32'd0;
  endtask

  // Waits for done starting from cycle cyc0, checks its cycle index and that it lasts one cycle.
  task automatic wait_done(input string tag, input int cyc0, input int exp_lat);
    int cyc;
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    @(negedge clk);
    chk({tag, "_done_width"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
    $display("txn %s: done at cycle %0d hi=%h lo=%h", tag, cyc, hi, lo);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    rst = 1'b0;

    issue(OP_MULTU, 32'hFFFFFFFF, 32'd2);
    chk("multu_busy", {63'd0, busy}, 64'd1);
    wait_done("multu", 1, MUL_LAT);
    chk("multu_result", {hi, lo}, 64'h00000001_FFFFFFFE);

    issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
    wait_done("mult_neg", 1, MUL_LAT);
    chk("mult_neg_result", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

    issue(OP_MULT, 32'h80000000, 32'h80000000);
    wait_done("mult_min", 1, MUL_LAT);
    chk("mult_min_result", {hi, lo}, 64'h40000000_00000000);

    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg", 1, DIV_LAT);
    chk("div_neg_result", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", 1, DIV_LAT);
    chk("div_ovf_result", {hi, lo}, 64'h00000000_80000000);

    @(negedge clk); mthi = 1'b1; wdata = 32'h0000AAAA;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h00005555;
    @(negedge clk); mtlo = 1'b0;
    chk("mt_loaded", {hi, lo}, 64'h0000AAAA_00005555);
    chk("mt_no_done", {63'd0, done}, 64'd0);
    $display("txn mthi/mtlo: hi=%h lo=%h", hi, lo);

    issue(OP_DIVU, 32'h00001234, 32'd0);
    wait_done("divu_zero", 1, ZERO_LAT);
    chk("divu_zero_result", {hi, lo}, 64'h0000AAAA_00005555);

    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h00000077;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
    chk("mt_both", {hi, lo}, 64'h00000077_00000077);
    $display("txn mthi+mtlo: hi=%h lo=%h", hi, lo);

    @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd4; mthi = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    chk("start_beats_mthi", {32'd0, hi}, 64'h77);
    wait_done("multu_small", 1, MUL_LAT);
    chk("multu_small_result", {hi, lo}, 64'h00000000_0000000C);

    issue(OP_DIVU, 32'd100, 32'd7);
    start = 1'b1; op = OP_DIVU; a = 32'd1; b = 32'd1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000FFFF;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    chk("busy_mt_ignored", {hi, lo}, 64'h00000000_0000000C);
    wait_done("divu_busy", 2, DIV_LAT);
    chk("divu_busy_result", {hi, lo}, 64'h00000002_0000000E);

    issue(OP_DIVU, 32'd50, 32'd5);
    repeat (9) @(negedge clk);
    chk("run10_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    chk("midrst_hold", {hi, lo}, 64'd0);
    $display("txn reset mid-run: busy=%b hi=%h lo=%h", busy, hi, lo);

    issue(OP_DIVU, 32'd9, 32'd3);
    wait_done("divu_after_rst", 1, DIV_LAT);
    chk("divu_after_rst_result", {hi, lo}, 64'h00000000_00000003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
